// File: rtl/serial_loader.sv
// Serial boot loader: parses SYNC/ADDR/CNT/words/CSUM frames from a byte stream,
// writes 16-bit words into instruction RAM and answers each frame with ACK or NAK.
module serial_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [7:0]  ACK_BYTE  = 8'h06,
    parameter logic [7:0]  NAK_BYTE  = 8'h15,
    parameter int unsigned TIMEOUT   = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_full,
    output logic        tx_send,
    output logic [7:0]  tx_data,
    output logic        load_we,
    output logic [7:0]  load_addr,
    output logic [15:0] load_data,
    output logic        cpu_hold,
    output logic        err_timeout
);

    localparam int unsigned TmoW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle, StAddr, StCnt, StHi, StLo, StCsum, StResp
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       ptr_q, ptr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       hi_q, hi_d;
    logic [7:0]       csum_q, csum_d;
    logic [7:0]       resp_q, resp_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic             load_we_q, load_we_d;
    logic [7:0]       load_addr_q, load_addr_d;
    logic [15:0]      load_data_q, load_data_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             err_q, err_d;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        csum_d      = csum_q;
        resp_d      = resp_q;
        tmo_d       = '0;
        load_we_d   = 1'b0;
        load_addr_d = load_addr_q;
        load_data_d = load_data_q;
        tx_data_d   = tx_data_q;
        err_d       = 1'b0;
        tx_send     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d = StAddr;
                    csum_d  = '0;
                end
            end
            StAddr: begin
                if (rx_valid) begin
                    ptr_d   = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = StCnt;
                end
            end
            StCnt: begin
                if (rx_valid) begin
                    cnt_d   = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = (rx_data == 8'd0) ? StCsum : StHi;
                end
            end
            StHi: begin
                if (rx_valid) begin
                    hi_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = StLo;
                end
            end
            StLo: begin
                // Write is registered: strobe appears the cycle after the low byte.
                if (rx_valid) begin
                    load_we_d   = 1'b1;
                    load_addr_d = ptr_q;
                    load_data_d = {hi_q, rx_data};
                    ptr_d       = ptr_q + 8'd1;
                    cnt_d       = cnt_q - 8'd1;
                    csum_d      = csum_q ^ rx_data;
                    state_d     = (cnt_q == 8'd1) ? StCsum : StHi;
                end
            end
            StCsum: begin
                if (rx_valid) begin
                    resp_d  = (rx_data == csum_q) ? ACK_BYTE : NAK_BYTE;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (!tx_full) begin
                    tx_send   = 1'b1;
                    tx_data_d = resp_q;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A byte arriving in the same cycle the limit is reached wins over the abort.
        if (state_q inside {StAddr, StCnt, StHi, StLo, StCsum} && !rx_valid) begin
            if (tmo_q == TmoMax) begin
                state_d = StIdle;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            cnt_q       <= '0;
            hi_q        <= '0;
            csum_q      <= '0;
            resp_q      <= '0;
            tmo_q       <= '0;
            load_we_q   <= 1'b0;
            load_addr_q <= '0;
            load_data_q <= '0;
            tx_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            csum_q      <= csum_d;
            resp_q      <= resp_d;
            tmo_q       <= tmo_d;
            load_we_q   <= load_we_d;
            load_addr_q <= load_addr_d;
            load_data_q <= load_data_d;
            tx_data_q   <= tx_data_d;
            err_q       <= err_d;
        end
    end

    // tx_data shows the response only while the strobe is up, then holds it.
    assign tx_data     = tx_send ? resp_q : tx_data_q;
    assign cpu_hold    = (state_q != StIdle) && !tx_send;
    assign load_we     = load_we_q;
    assign load_addr   = load_addr_q;
    assign load_data   = load_data_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_serial_loader.sv
// Self-checking bench for serial_loader: directed frames plus randomized frames
// compared against a frame-level reference model.
module tb_serial_loader;

    localparam int unsigned TMO  = 40;
    localparam logic [7:0]  SYNC = 8'hA5;
    localparam logic [7:0]  ACK  = 8'h06;
    localparam logic [7:0]  NAK  = 8'h15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_full = 1'b0;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic        load_we;
    logic [7:0]  load_addr;
    logic [15:0] load_data;
    logic        cpu_hold;
    logic        err_timeout;

    always #5 clk = ~clk;

    serial_loader #(
        .SYNC_BYTE (SYNC),
        .ACK_BYTE  (ACK),
        .NAK_BYTE  (NAK),
        .TIMEOUT   (TMO)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_full     (tx_full),
        .tx_send     (tx_send),
        .tx_data     (tx_data),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .cpu_hold    (cpu_hold),
        .err_timeout (err_timeout)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observation: everything the DUT emits, sampled at the falling edge.
    logic [23:0] got_wr[$];
    logic [7:0]  got_tx[$];
    int          got_err = 0;
    int          n_viol = 0;
    logic        prev_rst = 1'b0;
    logic        prev_we = 1'b0;
    logic        prev_hold = 1'b0;
    logic [23:0] prev_ld = '0;
    logic [7:0]  prev_tx = '0;

    always @(negedge clk) begin
        if (rst) begin
            if (load_we) got_wr.push_back({load_addr, load_data});
            if (tx_send) got_tx.push_back(tx_data);
            if (err_timeout) got_err++;
            if (prev_rst) begin
                if (!load_we && {load_addr, load_data} != prev_ld) n_viol++;
                if (!tx_send && tx_data != prev_tx) n_viol++;
                if (load_we && prev_we) n_viol++;
                if (tx_send && (cpu_hold || !prev_hold)) n_viol++;
            end
        end
        prev_rst  <= rst;
        prev_we   <= load_we;
        prev_hold <= cpu_hold;
        prev_ld   <= {load_addr, load_data};
        prev_tx   <= tx_data;
    end

    // Reference model: expectations derived from the frame contents.
    logic [7:0]  frm[$];
    int          gap[$];
    logic [23:0] exp_wr[$];
    logic [7:0]  exp_tx[$];
    int          exp_err;

    function automatic logic [7:0] xor_range(input int last);
        logic [7:0] x = 8'h00;
        for (int i = 1; i <= last; i++) x ^= frm[i];
        return x;
    endfunction

    // m = number of bytes after SYNC that were sent; complete frames include CSUM.
    task automatic model_frame(input int m, input bit complete);
        int         nw;
        logic [7:0] a;
        nw = complete ? int'(frm[2]) : ((m < 2) ? 0 : (m - 2) / 2);
        for (int k = 0; k < nw; k++) begin
            a = frm[1] + 8'(k);
            exp_wr.push_back({a, frm[3 + 2 * k], frm[4 + 2 * k]});
        end
        if (complete) begin
            exp_tx.push_back((frm[frm.size() - 1] == xor_range(frm.size() - 2)) ? ACK : NAK);
        end else begin
            exp_err = 1;
        end
    endtask

    task automatic clear_all();
        got_wr.delete();
        got_tx.delete();
        got_err = 0;
        exp_wr.delete();
        exp_tx.delete();
        exp_err = 0;
    endtask

    task automatic compare(input string tag);
        check({tag, ".nwr"}, got_wr.size(), exp_wr.size());
        for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
            check({tag, ".wr"}, got_wr[i], exp_wr[i]);
        check({tag, ".ntx"}, got_tx.size(), exp_tx.size());
        for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++)
            check({tag, ".tx"}, got_tx[i], exp_tx[i]);
        check({tag, ".err"}, got_err, exp_err);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input string tag);
        for (int w = 0; w < 60 && got_tx.size() == 0; w++) tick(1);
        check({tag, ".resp_seen"}, (got_tx.size() != 0), 1);
    endtask

    // Sends frm[0..m] with gap[] idle cycles before each byte.
    task automatic drive_frame(input int m, input int hold);
        bit complete;
        complete = (m == frm.size() - 1);
        for (int i = 0; i <= m; i++) begin
            tick(gap[i]);
            if (complete && i == m && hold > 0) tx_full = 1'b1;
            send_byte(frm[i]);
        end
        if (complete) begin
            tick(hold);
            tx_full = 1'b0;
            wait_tx("frame");
            tick(2);
        end else begin
            tick(TMO + 4);
        end
    endtask

    task automatic zero_gaps();
        gap.delete();
        for (int i = 0; i < frm.size(); i++) gap.push_back(0);
    endtask

    initial begin
        int         cnt, m, hold;
        logic [7:0] b;
        bit         trunc;

        // Reset state, asynchronous
        #2;
        check("rst.tx_send", tx_send, 0);
        check("rst.tx_data", tx_data, 0);
        check("rst.load_we", load_we, 0);
        check("rst.load_addr", load_addr, 0);
        check("rst.load_data", load_data, 0);
        check("rst.cpu_hold", cpu_hold, 0);
        check("rst.err", err_timeout, 0);
        tick(2);
        rst = 1'b1;
        tick(2);

        // Good two-word frame with cycle-level checks
        clear_all();
        frm = {SYNC, 8'h10, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        frm.push_back(xor_range(frm.size() - 1));
        check("good.csum_const", frm[7], 8'h52);
        @(negedge clk);
        check("good.hold_idle", cpu_hold, 0);
        send_byte(SYNC);
        @(negedge clk);
        check("good.hold_sync1", cpu_hold, 1);
        send_byte(8'h10);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        @(negedge clk);
        check("good.we1", load_we, 1);
        check("good.wr1", {load_addr, load_data}, 24'h101234);
        send_byte(8'hAB);
        send_byte(8'hCD);
        @(negedge clk);
        check("good.we2", load_we, 1);
        send_byte(frm[7]);
        @(negedge clk);
        check("good.tx_send", tx_send, 1);
        check("good.tx_data", tx_data, ACK);
        check("good.hold_tx", cpu_hold, 0);
        tick(3);
        model_frame(7, 1'b1);
        compare("good");

        // Bad checksum: writes still happen, NAK returned
        clear_all();
        frm[7] = 8'h53;
        zero_gaps();
        drive_frame(7, 0);
        model_frame(7, 1'b1);
        compare("badcsum");

        // Pointer wrap FF -> 00
        clear_all();
        frm = {SYNC, 8'hFF, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        frm.push_back(xor_range(frm.size() - 1));
        zero_gaps();
        drive_frame(7, 0);
        model_frame(7, 1'b1);
        compare("wrap");

        // Zero-count frame, then a stray byte in IDLE
        clear_all();
        frm = {SYNC, 8'h20, 8'h00, 8'h20};
        zero_gaps();
        drive_frame(3, 0);
        model_frame(3, 1'b1);
        compare("cnt0");
        clear_all();
        send_byte(8'h55);
        @(negedge clk);
        check("stray.hold", cpu_hold, 0);
        tick(3);
        compare("stray");

        // Timeout after ADDR, exact pulse cycle
        clear_all();
        send_byte(SYNC);
        send_byte(8'h10);
        tick(TMO);
        @(negedge clk);
        check("tmo.early_err", err_timeout, 0);
        tick(1);
        @(negedge clk);
        check("tmo.err", err_timeout, 1);
        check("tmo.hold", cpu_hold, 0);
        tick(3);
        exp_err = 1;
        compare("tmo");

        // Gaps of exactly TIMEOUT cycles: byte wins, frame completes
        clear_all();
        frm = {SYNC, 8'h30, 8'h01, 8'h5A, 8'hC3};
        frm.push_back(xor_range(frm.size() - 1));
        gap = {0, TMO, TMO, 0, TMO, TMO};
        drive_frame(5, 0);
        model_frame(5, 1'b1);
        compare("tmo_edge");

        // tx_full back-pressure; a SYNC during RESP is ignored
        clear_all();
        frm = {SYNC, 8'h40, 8'h01, 8'h12, 8'h34};
        frm.push_back(xor_range(frm.size() - 1));
        tx_full = 1'b1;
        foreach (frm[i]) send_byte(frm[i]);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) send_byte(SYNC);
            else tick(1);
        end
        check("txfull.held", got_tx.size(), 0);
        tx_full = 1'b0;
        @(negedge clk);
        check("txfull.send", tx_send, 1);
        check("txfull.data", tx_data, ACK);
        tick(3);
        check("resp_ignore.hold", cpu_hold, 0);
        model_frame(5, 1'b1);
        compare("txfull");

        // Reset while in HI
        clear_all();
        send_byte(SYNC);
        send_byte(8'h10);
        send_byte(8'h02);
        @(negedge clk);
        check("midrst.hold_before", cpu_hold, 1);
        rst = 1'b0;
        #1;
        check("midrst.outs",
              {tx_send, tx_data, load_we, load_addr, load_data, cpu_hold, err_timeout}, 0);
        tick(2);
        rst = 1'b1;
        tick(1);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
        tick(4);
        check("midrst.hold_after", cpu_hold, 0);
        compare("midrst");

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            clear_all();
            for (int n = $urandom_range(0, 2); n > 0; n--) begin
                b = 8'($urandom);
                if (b == SYNC) b = b ^ 8'h01;
                tick($urandom_range(0, 3));
                send_byte(b);
            end
            cnt = $urandom_range(0, 4);
            frm = {SYNC, 8'($urandom), 8'(cnt)};
            for (int i = 0; i < 2 * cnt; i++) frm.push_back(8'($urandom));
            b = xor_range(frm.size() - 1);
            if ($urandom_range(0, 3) == 0) b = b ^ 8'(1 << $urandom_range(0, 7));
            frm.push_back(b);
            gap.delete();
            foreach (frm[i]) gap.push_back(($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, 3));
            trunc = ($urandom_range(0, 3) == 0);
            m     = trunc ? $urandom_range(0, 2 + 2 * cnt) : frm.size() - 1;
            hold  = trunc ? 0 : $urandom_range(0, 5);
            drive_frame(m, hold);
            model_frame(m, !trunc);
            compare($sformatf("rand%0d", f));
        end

        check("protocol_viol", n_viol, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_loader.md
SERIAL_LOADER -- requirements
Module: serial_loader

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-002 SHALL have parameter ACK_BYTE, default 8'h06, the response to a good frame.
REQ-003 SHALL have parameter NAK_BYTE, default 8'h15, the response to a bad-checksum frame.
REQ-004 SHALL have parameter TIMEOUT, default 50000, the maximum idle cycles between bytes inside a frame.
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on posedge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port rx_valid  input  1  one-cycle strobe: rx_data holds a received byte.
REQ-008 SHALL have port rx_data  input  8  received byte.
REQ-009 SHALL have port tx_full  input  1  transmitter cannot accept a byte.
REQ-010 SHALL have port tx_send  output  1  one-cycle strobe: transmit tx_data.
REQ-011 SHALL have port tx_data  output  8  response byte.
REQ-012 SHALL have port load_we  output  1  one-cycle instruction-RAM write strobe.
REQ-013 SHALL have port load_addr  output  8  RAM word address.
REQ-014 SHALL have port load_data  output  16  RAM write word.
REQ-015 SHALL have port cpu_hold  output  1  high while a frame is in progress; processor held in reset.
REQ-016 SHALL have port err_timeout  output  1  one-cycle pulse on frame abort.

Function
REQ-017 SHALL accept a frame of: SYNC_BYTE, ADDR, CNT, CNT words (high byte first, then low byte), CSUM.
REQ-018 SHALL implement states IDLE, ADDR, CNT, HI, LO, CSUM, RESP.
REQ-019 SHALL, in IDLE, ignore every byte except SYNC_BYTE. On SYNC_BYTE it SHALL go to ADDR and set cpu_hold on the next cycle.
REQ-020 SHALL, in ADDR, latch the byte as the word pointer and go to CNT.
REQ-021 SHALL, in CNT, latch the byte as the remaining-word count. It SHALL go to HI if CNT is nonzero and to CSUM if CNT is 0.
REQ-022 SHALL, in HI, latch the byte as load_data[15:8] and go to LO.
REQ-023 SHALL, in LO, on the byte's rx_valid cycle plus one, drive load_we=1 for exactly one cycle with load_addr = pointer and load_data = {HI byte, LO byte}.
REQ-024 SHALL, after that write, increment the pointer modulo 256 (8'hFF wraps to 8'h00) and decrement the count. It SHALL go to HI if the count is still nonzero and to CSUM otherwise.
REQ-025 SHALL keep a running XOR of ADDR, CNT and every data byte, cleared on SYNC acceptance.
REQ-026 SHALL, in CSUM, compare the received byte with the running XOR. It SHALL select ACK_BYTE on a match and NAK_BYTE on a mismatch, then go to RESP.
REQ-027 SHALL perform data writes regardless of checksum outcome; a NAK reports the error only.
REQ-028 SHALL, in RESP, wait while tx_full=1. In the first cycle with tx_full=0 it SHALL pulse tx_send for one cycle with tx_data = the selected byte, then go to IDLE.
REQ-029 SHALL clear cpu_hold in the cycle tx_send is asserted.
REQ-030 SHALL ignore rx_valid while in RESP.
REQ-031 SHALL keep a timeout counter that clears on every rx_valid and on entry to any state other than IDLE.
REQ-032 SHALL run the timeout counter in ADDR, CNT, HI, LO and CSUM.
REQ-033 SHALL, when the timeout counter reaches TIMEOUT, go to IDLE, pulse err_timeout for one cycle, clear cpu_hold, and send no response.
REQ-034 SHALL give rx_valid priority if it arrives in the same cycle the counter reaches TIMEOUT; the byte is consumed and the frame continues.
REQ-035 SHALL hold tx_data, load_addr and load_data stable when their strobes are low.

Reset
REQ-036 SHALL, while rst=0, force state IDLE and drive tx_send=0, tx_data=0, load_we=0, load_addr=0, load_data=0, cpu_hold=0 and err_timeout=0, independent of clk.
REQ-037 SHALL abort any partial frame on reset mid-frame; no write or response is issued after rst returns high.
REQ-038 SHALL leave RAM contents already written untouched on reset.

Verification
REQ-039 SHALL pass: bytes A5,10,02,12,34,AB,CD,(10^02^12^34^AB^CD) -> two writes (addr 10, data 1234) then (addr 11, data ABCD); one tx_send with 06; cpu_hold high from the SYNC cycle+1 to the tx_send cycle.
REQ-040 SHALL pass: same frame with CSUM wrong -> both writes occur; tx_data=15.
REQ-041 SHALL pass: A5,FF,02 then two words -> writes to addr FF then 00.
REQ-042 SHALL pass: A5,20,00,20 -> no load_we; ACK. Byte 55 in IDLE -> ignored, cpu_hold stays 0.
REQ-043 SHALL pass: A5,10 then silence for TIMEOUT cycles -> err_timeout pulse, cpu_hold=0, no tx_send; a following A5 starts a new frame.
REQ-044 SHALL pass: tx_full held high 20 cycles in RESP -> tx_send waits until tx_full falls. Separately, rst=0 during HI -> all outputs 0 immediately, no further write.
